// File: rtl/bcd_pkg.sv
// Shared constants and the state type for the serial BCD adder.
package bcd_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } bcd_ser_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary sum of two digits and a carry, then decimal correction.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] t;

   always_comb begin
      t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      s = t[3:0];
      cout = 1'b0;
      // Adding 6 in four bits skips the six unused codes and wraps back into 0..9.
      if (t > {1'b0, BCD_MAX}) begin
         s = t[3:0] + BCD_CORR;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder that processes one digit per clock, least significant first,
// behind a start/busy/done handshake.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BCD_W*DIGITS-1:0] a,
   input  logic [BCD_W*DIGITS-1:0] b,
   input  logic                    carryIn,
   output logic                    busy,
   output logic                    done,
   output logic [BCD_W*DIGITS-1:0] sum,
   output logic                    carryOut,
   output logic                    invalid
);

   localparam int W     = BCD_W * DIGITS;
   localparam int CNT_W = $clog2(DIGITS + 1);

   bcd_ser_state_t state_q, state_d;
   logic [W-1:0]     a_sr_q, a_sr_d;
   logic [W-1:0]     b_sr_q, b_sr_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;
   logic             invalid_q, invalid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [3:0] dig_s;
   logic       dig_cout;

   bcd_digit_add u_digit (
      .a    (a_sr_q[BCD_W-1:0]),
      .b    (b_sr_q[BCD_W-1:0]),
      .cin  (carry_q),
      .s    (dig_s),
      .cout (dig_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      invalid_d   = invalid_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               a_sr_d      = a;
               b_sr_d      = b;
               carry_d     = carryIn;
               cnt_d       = '0;
               sum_d       = '0;
               carry_out_d = 1'b0;
               invalid_d   = 1'b0;
               busy_d      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  sum_d[i*BCD_W +: BCD_W] = dig_s;
               end
            end
            // Invalid digits are detected as they pass through the adder.
            invalid_d = invalid_q | (a_sr_q[BCD_W-1:0] > BCD_MAX)
                                  | (b_sr_q[BCD_W-1:0] > BCD_MAX);
            carry_d   = dig_cout;
            a_sr_d    = a_sr_q >> BCD_W;
            b_sr_d    = b_sr_q >> BCD_W;
            cnt_d     = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d     = DONE;
               carry_out_d = dig_cout;
               done_d      = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         invalid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         invalid_q   <= invalid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryOut = carry_out_q;
   assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed-vector bench for bcd_serial_adder with DIGITS = 4, plus an exhaustive digit-adder sweep.
module tb_bcd_serial_adder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        carryIn;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        carryOut;
   logic        invalid;

   logic [3:0]  dA;
   logic [3:0]  dB;
   logic        dCin;
   logic [3:0]  dS;
   logic        dCout;

   int total = 0;
   int bad   = 0;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .carryIn  (carryIn),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryOut (carryOut),
      .invalid  (invalid)
   );

   bcd_digit_add u_dig (
      .a    (dA),
      .b    (dB),
      .cin  (dCin),
      .s    (dS),
      .cout (dCout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents operands with start for one edge; returns 1ns after the accepting edge.
   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cin);
      a       = av;
      b       = bv;
      carryIn = cin;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   // Waits (bounded) for done; lat is the number of edges after the accepting edge, -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      total++;
      if ({busy, done, sum, carryOut, invalid} !== 20'h0) begin
         bad++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
                  busy, done, sum, carryOut, invalid);
      end
   endtask

   task automatic test_basic();
      launch(16'h1234, 16'h5678, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
         end
         step();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || sum !== 16'h6912 || carryOut !== 1'b0 || invalid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_result: got done=%b busy=%b sum=%h cout=%b inv=%b, want 1 0 6912 0 0",
                  done, busy, sum, carryOut, invalid);
      end
      step();
      total++;
      if (done !== 1'b0 || sum !== 16'h6912) begin
         bad++;
         $display("[TB] FAIL basic_hold: got done=%b sum=%h, want done=0 sum=6912", done, sum);
      end
      step();
   endtask

   task automatic test_vectors();
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic        vc [5];
      logic [15:0] es [5];
      logic        ec [5];
      logic        ei [5];
      int lat;
      va = '{16'h9999, 16'h9999, 16'h0500, 16'h0000, 16'h12A4};
      vb = '{16'h0001, 16'h9999, 16'h0500, 16'h0000, 16'h0001};
      vc = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
      es = '{16'h0000, 16'h9999, 16'h1000, 16'h0001, 16'h1305};
      ec = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
      ei = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
      for (int i = 0; i < 5; i++) begin
         launch(va[i], vb[i], vc[i]);
         wait_done(lat);
         total++;
         if (lat != 4 || sum !== es[i] || carryOut !== ec[i] || invalid !== ei[i]) begin
            bad++;
            $display("[TB] FAIL vector[%0d] %h+%h+%b: got lat=%0d sum=%h cout=%b inv=%b, want lat=4 sum=%h cout=%b inv=%b",
                     i, va[i], vb[i], vc[i], lat, sum, carryOut, invalid, es[i], ec[i], ei[i]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bit sawDone;
      launch(16'h1234, 16'h5678, 1'b0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || sum !== 16'h0 || carryOut !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrun_reset: got busy=%b sum=%h cout=%b done=%b, want 0 0000 0 0",
                  busy, sum, carryOut, done);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done) sawDone = 1'b1;
         step();
      end
      total++;
      if (sawDone) begin
         bad++;
         $display("[TB] FAIL midrun_no_done: got done pulse=1, want 0");
      end
      launch(16'h0005, 16'h0005, 1'b0);
      wait_done(lat);
      total++;
      if (lat != 4 || sum !== 16'h0010 || carryOut !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrun_restart: got lat=%0d sum=%h cout=%b, want lat=4 sum=0010 cout=0",
                  lat, sum, carryOut);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int doneAt [$];
      bit prevDone;
      a       = 16'h1111;
      b       = 16'h2222;
      carryIn = 1'b0;
      start   = 1'b1;
      prevDone = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         step();
         if (prevDone) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("[TB] FAIL b2b_no_idle@%0d: got busy=%b, want 1", cyc, busy);
            end
         end
         if (done) begin
            doneAt.push_back(cyc);
            total++;
            if (sum !== 16'h3333) begin
               bad++;
               $display("[TB] FAIL b2b_sum@%0d: got %h, want 3333", cyc, sum);
            end
         end
         prevDone = done;
      end
      start = 1'b0;
      total++;
      if (doneAt.size() < 3) begin
         bad++;
         $display("[TB] FAIL b2b_count: got %0d done pulses, want >=3", doneAt.size());
      end else if (doneAt[1] - doneAt[0] != 5 || doneAt[2] - doneAt[1] != 5) begin
         bad++;
         $display("[TB] FAIL b2b_spacing: got %0d,%0d, want 5,5",
                  doneAt[1] - doneAt[0], doneAt[2] - doneAt[1]);
      end
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_digit_exhaustive();
      int exp;
      for (int x = 0; x < 10; x++) begin
         for (int y = 0; y < 10; y++) begin
            for (int c = 0; c < 2; c++) begin
               dA   = 4'(x);
               dB   = 4'(y);
               dCin = c[0];
               #1;
               exp = x + y + c;
               total++;
               if (dCout !== (exp >= 10) || dS !== 4'(exp % 10)) begin
                  bad++;
                  $display("[TB] FAIL digit %0d+%0d+%0d: got cout=%b s=%0d, want cout=%b s=%0d",
                           x, y, c, dCout, dS, (exp >= 10), exp % 10);
               end
            end
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      carryIn = 1'b0;
      dA      = '0;
      dB      = '0;
      dCin    = 1'b0;
      test_reset();
      test_basic();
      test_vectors();
      test_reset_mid_run();
      test_back_to_back();
      test_digit_exhaustive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Multi-digit BCD adder that adds two packed BCD operands plus a carry-in one decimal digit per clock, least-significant digit first. A start/busy/done handshake sits in front of a single combinational BCD digit adder and chains the carry between digits through a register. It produces a packed BCD sum and a decimal carry-out, so wide decimal arithmetic costs one digit adder and DIGITS cycles.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  4*DIGITS  BCD operand, packed, digit 0 in [3:0]; sampled on the accepted start.
- b  input  4*DIGITS  BCD operand, same packing; sampled on the accepted start.
- carryIn  input  1  decimal carry into digit 0; sampled on the accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is complete.
- sum  output  4*DIGITS  BCD result, same packing.
- carryOut  output  1  decimal carry out of the top digit.
- invalid  output  1  high if any digit of the captured a or b was >9.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE goes to RUN on start.
  - RUN goes to DONE after DIGITS digit steps.
  - DONE goes to RUN if start is high, otherwise to IDLE.
- On an accepted start:
  - a, b and carryIn are latched into operand shift registers and the carry register.
  - The digit counter clears to 0.
  - sum, carryOut and invalid clear to 0.
- Each RUN cycle:
  - Adds the low digits of the operand registers and the carry register.
  - Writes the result digit into sum at position counter.
  - Updates the carry register.
  - Shifts the operand registers right by 4 bits and increments the counter.
- Digit rule, with t = a_d + b_d + c computed 5 bits wide:
  - If t > 9: digit = (t + 6) mod 16 and carry = 1.
  - Otherwise: digit = t[3:0] and carry = 0.
- invalid is the OR, over the captured operands, of (digit > 9). The sum is still computed by the digit rule and is undefined as decimal when invalid = 1.
- start is ignored in RUN. The operands are not re-sampled until the next accepted start.
- sum, carryOut and invalid hold from done until the next accepted start.

## Timing
- Reset values:
  - State is IDLE.
  - busy, done, sum, carryOut and invalid are all 0.
  - Internal carry, counter and operand registers are 0.
- Start is sampled at edge k.
- busy is high from after edge k until edge k+DIGITS.
- The last digit and carryOut are registered at edge k+DIGITS.
- done is high for exactly the cycle after edge k+DIGITS, with sum and carryOut valid.
- Latency from start to done is DIGITS+1 cycles.
- Back-to-back throughput is one operation per DIGITS+1 cycles, by asserting start during DONE.
- Reset asserted in any state, including mid-RUN:
  - Returns to the reset values at that edge.
  - No done pulse is produced for the aborted operation.
- When reset and start are high together, reset wins.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4, BCD_MAX = 9, BCD_CORR = 6.
  - The state enum type bcd_ser_state_t.
- Sub-module bcd_digit_add is purely combinational and implements the digit rule:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
- Top level holds the FSM, the counter (width $clog2(DIGITS+1)), the operand shift registers and the result register.

## Test plan
All scenarios use DIGITS = 4.
- a=1234, b=5678, carryIn=0, start at edge k: busy for 4 cycles, then a done pulse at cycle k+5 with sum=6912, carryOut=0, invalid=0.
- a=9999, b=0001, carryIn=0: sum=0000, carryOut=1. a=9999, b=9999, carryIn=1: sum=9999, carryOut=1.
- a=0x12A4, b=0x0001: invalid=1 with done; the a=0 and b=0 case from an exhaustive single-digit sweep passes separately. Exhaustive bcd_digit_add check over 0..9 x 0..9 x cin: {cout,s} equals the decimal sum.
- Reset asserted in the 2nd RUN cycle:
  - On the next cycle busy=0, sum=0 and carryOut=0.
  - No done pulse for the following 10 cycles.
  - A fresh start of 0005+0005 gives 0010.
- start held high throughout:
  - Pulses during RUN are ignored.
  - start in DONE launches the next operation with no IDLE cycle.
  - done pulses are spaced exactly 5 cycles apart.
